// File: rtl/bsg_manycore_host_link_arbiter_pkg.sv
// rtl/bsg_manycore_host_link_arbiter_pkg.sv - shared types, constants and tag helpers for the host link arbiter
package bsg_manycore_host_link_arbiter_pkg;

   typedef enum logic {IDLE, SEND} state_e;

   localparam int stats_width_lp      = 32;
   localparam int packet_max_width_lp = 1024;
   localparam int tag_max_width_lp    = 8;

   typedef logic [packet_max_width_lp-1:0] packet_max_t;
   typedef logic [tag_max_width_lp-1:0]    tag_max_t;

   function automatic packet_max_t tag_insert(packet_max_t pkt, logic [9:0] lsb, logic [9:0] width, tag_max_t tag);
      packet_max_t r;
      logic [9:0]  idx;
      r = pkt;
      for (int i = 0; i < tag_max_width_lp; i++) begin
         idx = lsb + 10'(i);
         if (10'(i) < width) r[idx] = tag[i];
      end
      return r;
   endfunction

   function automatic tag_max_t tag_extract(packet_max_t pkt, logic [9:0] lsb, logic [9:0] width);
      tag_max_t   t;
      logic [9:0] idx;
      t = '0;
      for (int i = 0; i < tag_max_width_lp; i++) begin
         idx = lsb + 10'(i);
         if (10'(i) < width) t[i] = pkt[idx];
      end
      return t;
   endfunction

endpackage

// File: rtl/bsg_manycore_host_link_arbiter_if.sv
// rtl/bsg_manycore_host_link_arbiter_if.sv - requester, link and response handshake bundle
interface bsg_manycore_host_link_arbiter_if #(
   parameter int num_req_p      = 2,
   parameter int packet_width_p = 128
);
   logic [num_req_p-1:0]                req_v_i;
   logic [num_req_p*packet_width_p-1:0] req_packet_i;
   logic [num_req_p-1:0]                req_ready_o;
   logic                                link_req_v_o;
   logic [packet_width_p-1:0]           link_req_packet_o;
   logic                                link_req_ready_i;
   logic                                link_resp_v_i;
   logic [packet_width_p-1:0]           link_resp_packet_i;
   logic                                link_resp_yumi_o;
   logic [num_req_p-1:0]                resp_v_o;
   logic [packet_width_p-1:0]           resp_packet_o;
   logic [num_req_p-1:0]                resp_ready_i;

   modport slave (
      input  req_v_i, req_packet_i, link_req_ready_i, link_resp_v_i, link_resp_packet_i, resp_ready_i,
      output req_ready_o, link_req_v_o, link_req_packet_o, link_resp_yumi_o, resp_v_o, resp_packet_o
   );

   modport master (
      output req_v_i, req_packet_i, link_req_ready_i, link_resp_v_i, link_resp_packet_i, resp_ready_i,
      input  req_ready_o, link_req_v_o, link_req_packet_o, link_resp_yumi_o, resp_v_o, resp_packet_o
   );
endinterface

// File: rtl/bsg_manycore_host_link_rr_pick.sv
// rtl/bsg_manycore_host_link_rr_pick.sv - combinational round-robin pick starting at the pointer
module bsg_manycore_host_link_rr_pick #(
   parameter int num_req_p   = 2,
   parameter int idx_width_p = 1
) (
   input  logic [num_req_p-1:0]   req_i,
   input  logic [idx_width_p-1:0] ptr_i,
   output logic [num_req_p-1:0]   grant_o,
   output logic [idx_width_p-1:0] grant_idx_o,
   output logic                   any_v_o
);
   always_comb begin
      int j;
      grant_o     = '0;
      grant_idx_o = '0;
      any_v_o     = |req_i;
      // Walk offsets from farthest to nearest so the nearest requester wins.
      for (int k = num_req_p - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % num_req_p;
         if (req_i[j]) grant_idx_o = idx_width_p'(j);
      end
      if (any_v_o) grant_o[grant_idx_o] = 1'b1;
   end
endmodule

// File: rtl/bsg_manycore_host_link_arbiter.sv
// rtl/bsg_manycore_host_link_arbiter.sv - credit-throttled round-robin host link arbiter; stats via BSG_MANYCORE_HOST_LINK_ARBITER_STATS_EN
module bsg_manycore_host_link_arbiter
   import bsg_manycore_host_link_arbiter_pkg::*;
#(
   parameter int num_req_p         = 2,
   parameter int packet_width_p    = 128,
   parameter int tag_lsb_p         = 0,
   parameter int max_out_credits_p = 16,
   localparam int tag_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1,
   localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
   input  logic                                            clk_i,
   input  logic                                            reset_n_i,
   bsg_manycore_host_link_arbiter_if.slave                 link_if,
   output logic [credit_width_lp-1:0]                      credits_o,
   output logic [num_req_p*stats_width_lp+stats_width_lp-1:0] stats_o
);
   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

   state_e                    state_q, state_d;
   logic [tag_width_lp-1:0]   rr_q, rr_d, grant_idx, resp_idx;
   logic [credit_width_lp-1:0] credits_q, credits_d;
   logic [packet_width_p-1:0] pkt_q, pkt_d;
   logic [num_req_p-1:0]      grant_oh;
   logic                      any_v, issue, yumi, tag_ok;
   tag_max_t                  resp_tag;

   bsg_manycore_host_link_rr_pick #(.num_req_p(num_req_p), .idx_width_p(tag_width_lp)) pick (
      .req_i(link_if.req_v_i), .ptr_i(rr_q), .grant_o(grant_oh), .grant_idx_o(grant_idx), .any_v_o(any_v)
   );

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      credits_d = credits_q;
      pkt_d     = pkt_q;
      // The output stage frees up either when idle or on the cycle the link takes its packet.
      issue = (credits_q != '0) && any_v && (state_q == IDLE || link_if.link_req_ready_i);
      link_if.req_ready_o = issue ? grant_oh : '0;
      if (issue) begin
         state_d = SEND;
         pkt_d   = packet_width_p'(tag_insert(packet_max_t'(link_if.req_packet_i[grant_idx*packet_width_p +: packet_width_p]),
                                              10'(tag_lsb_p), 10'(tag_width_lp), tag_max_t'(grant_idx)));
         rr_d    = (int'(grant_idx) == num_req_p - 1) ? '0 : grant_idx + 1'b1;
      end else if (state_q == SEND && link_if.link_req_ready_i) begin
         state_d = IDLE;
      end

      resp_tag = tag_extract(packet_max_t'(link_if.link_resp_packet_i), 10'(tag_lsb_p), 10'(tag_width_lp));
      tag_ok   = int'(resp_tag) < num_req_p;
      resp_idx = resp_tag[tag_width_lp-1:0];
      link_if.resp_v_o = '0;
      if (link_if.link_resp_v_i && tag_ok) link_if.resp_v_o[resp_idx] = 1'b1;
      // Bad tags are swallowed so their credit still comes back.
      yumi = link_if.link_resp_v_i && (!tag_ok || link_if.resp_ready_i[resp_idx]);

      case ({issue, yumi})
         2'b10:   credits_d = credits_q - 1'b1;
         2'b01:   if (credits_q != max_credits_lp) credits_d = credits_q + 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         credits_q <= max_credits_lp;
         pkt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         credits_q <= credits_d;
         pkt_q     <= pkt_d;
      end
   end

   assign link_if.link_req_v_o      = (state_q == SEND);
   assign link_if.link_req_packet_o = pkt_q;
   assign link_if.link_resp_yumi_o  = yumi;
   assign link_if.resp_packet_o     = link_if.link_resp_packet_i;
   assign credits_o                 = credits_q;

`ifdef BSG_MANYCORE_HOST_LINK_ARBITER_STATS_EN
   logic [stats_width_lp-1:0] issued_q [num_req_p];
   logic [stats_width_lp-1:0] issued_d [num_req_p];
   logic [stats_width_lp-1:0] stall_q, stall_d;

   always_comb begin
      for (int i = 0; i < num_req_p; i++)
         issued_d[i] = issued_q[i] + stats_width_lp'(link_if.req_ready_o[i]);
      stall_d = stall_q + stats_width_lp'((credits_q == '0) && (|link_if.req_v_i));
      stats_o = '0;
      for (int i = 0; i < num_req_p; i++) stats_o[i*stats_width_lp +: stats_width_lp] = issued_q[i];
      stats_o[num_req_p*stats_width_lp +: stats_width_lp] = stall_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < num_req_p; i++) issued_q[i] <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < num_req_p; i++) issued_q[i] <= issued_d[i];
         stall_q <= stall_d;
      end
   end
`else
   assign stats_o = '0;
`endif

   always @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(yumi && !issue && credits_q == max_credits_lp)) else $error("credit overflow on response");
         assert (!(link_if.link_resp_v_i && !tag_ok)) else $error("response tag out of range");
      end
   end
endmodule

// File: tb/tb_bsg_manycore_host_link_arbiter.sv
// tb/tb_bsg_manycore_host_link_arbiter.sv - randomized and directed bench for the host link arbiter
module tb_bsg_manycore_host_link_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bsg_manycore_host_link_arbiter_if #(.num_req_p(2), .packet_width_p(128)) ifa ();
   bsg_manycore_host_link_arbiter_if #(.num_req_p(2), .packet_width_p(128)) ifb ();
   logic [4:0]  credits_a;
   logic [1:0]  credits_b;
   logic [95:0] stats_a, stats_b;

   bsg_manycore_host_link_arbiter dut_a (
      .clk_i(clk), .reset_n_i(reset_n), .link_if(ifa), .credits_o(credits_a), .stats_o(stats_a)
   );
   bsg_manycore_host_link_arbiter #(.max_out_credits_p(2)) dut_b (
      .clk_i(clk), .reset_n_i(reset_n), .link_if(ifb), .credits_o(credits_b), .stats_o(stats_b)
   );

   int tests = 0;
   int fails = 0;
   // Reference model of dut_a: whether a packet sits on the link, its contents, pointer and credits.
   int           m_busy, m_rr, m_cred, last_g;
   logic [127:0] m_pkt;
   int           grants [4];
   int           acc;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_busy = 0; m_rr = 0; m_cred = 16; m_pkt = '0;
   endtask

   // Inputs of ifa are already driven; check one cycle against the model, then advance it.
   task automatic tick_a();
      int g, tg;
      logic [1:0] exp_ready, exp_rv;
      logic exp_yumi;
      #1;
      g = -1;
      if (m_cred > 0 && (m_busy == 0 || ifa.link_req_ready_i))
         for (int k = 0; k < 2; k++) begin
            int i;
            i = (m_rr + k) % 2;
            if (g < 0 && ifa.req_v_i[i]) g = i;
         end
      exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
      chk("req_ready", 128'(ifa.req_ready_o), 128'(exp_ready));
      chk("link_v", 128'(ifa.link_req_v_o), 128'(m_busy));
      if (m_busy != 0) chk("link_pkt", ifa.link_req_packet_o, m_pkt);
      chk("credits", 128'(credits_a), 128'(m_cred));
      tg       = int'(ifa.link_resp_packet_i[0]);
      exp_rv   = ifa.link_resp_v_i ? 2'(1 << tg) : 2'b00;
      exp_yumi = ifa.link_resp_v_i && ifa.resp_ready_i[tg];
      chk("resp_v", 128'(ifa.resp_v_o), 128'(exp_rv));
      chk("yumi", 128'(ifa.link_resp_yumi_o), 128'(exp_yumi));
      if (ifa.link_resp_v_i) chk("resp_pkt", ifa.resp_packet_o, ifa.link_resp_packet_i);
`ifndef BSG_MANYCORE_HOST_LINK_ARBITER_STATS_EN
      chk("stats_off", 128'(stats_a), 128'(0));
`endif
      if (g >= 0) begin
         m_pkt    = ifa.req_packet_i[g*128 +: 128];
         m_pkt[0] = g[0];
         m_rr     = (g + 1) % 2;
         m_cred   = m_cred - 1;
         m_busy   = 1;
      end else if (m_busy != 0 && ifa.link_req_ready_i) begin
         m_busy = 0;
      end
      if (exp_yumi && m_cred < 16) m_cred = m_cred + 1;
      last_g = g;
      @(negedge clk);
   endtask

   task automatic drive_a(input logic [1:0] rv, input logic lr, input logic pv, input logic [1:0] rr);
      ifa.req_v_i          = rv;
      ifa.req_packet_i     = {rnd128(), rnd128()};
      ifa.link_req_ready_i = lr;
      ifa.link_resp_v_i    = pv;
      ifa.resp_ready_i     = rr;
   endtask

   initial begin
      drive_a(2'b00, 1'b0, 1'b0, 2'b00);
      ifa.link_resp_packet_i = '0;
      ifb.req_v_i = '0; ifb.req_packet_i = '0; ifb.link_req_ready_i = 1'b0;
      ifb.link_resp_v_i = 1'b0; ifb.link_resp_packet_i = '0; ifb.resp_ready_i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_link_v", 128'(ifa.link_req_v_o), 128'(0));
      chk("rst_pkt", ifa.link_req_packet_o, 128'(0));
      chk("rst_ready", 128'(ifa.req_ready_o), 128'(0));
      chk("rst_credits", 128'(credits_a), 128'(16));
      reset_n = 1'b1;
      @(negedge clk);

      // Both requesting with the link always ready: grants alternate.
      for (int i = 0; i < 4; i++) begin
         drive_a(2'b11, 1'b1, 1'b0, 2'b00);
         tick_a();
         grants[i] = last_g;
      end
      for (int i = 0; i < 4; i++) chk("alternate", 128'(grants[i]), 128'(i % 2));
      chk("credits_after_4", 128'(credits_a), 128'(12));

      // Link stalls for 5 cycles, then accepts and a new grant is taken the same cycle.
      for (int i = 0; i < 5; i++) begin
         drive_a(2'b11, 1'b0, 1'b0, 2'b00);
         tick_a();
      end
      drive_a(2'b11, 1'b1, 1'b0, 2'b00);
      tick_a();
      chk("grant_on_ready", 128'(last_g >= 0), 128'(1));

      // Response for requester 1 blocked, then released.
      ifa.link_resp_packet_i = rnd128();
      ifa.link_resp_packet_i[0] = 1'b1;
      drive_a(2'b00, 1'b1, 1'b1, 2'b01);
      #1 chk("resp_v_tag1", 128'(ifa.resp_v_o), 128'(2'b10));
      tick_a();
      drive_a(2'b00, 1'b1, 1'b1, 2'b11);
      tick_a();
      chk("credits_after_yumi", 128'(credits_a), 128'(12));

      // Issue and yumi together at credits=7.
      for (int i = 0; i < 10 && m_cred > 7; i++) begin
         drive_a(2'b11, 1'b1, 1'b0, 2'b00);
         tick_a();
      end
      ifa.link_resp_packet_i[0] = 1'b0;
      drive_a(2'b11, 1'b1, 1'b1, 2'b11);
      tick_a();
      chk("credits_issue_yumi", 128'(credits_a), 128'(7));

      // Random traffic; responses only while requests are outstanding.
      for (int i = 0; i < 400; i++) begin
         drive_a(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'b0, 2'($urandom_range(0, 3)));
         ifa.link_resp_packet_i = rnd128();
         ifa.link_resp_v_i = (m_cred < 16) && ($urandom_range(0, 1) == 1);
         tick_a();
      end

      // Drain all credits back, then reset asynchronously mid-SEND.
      ifa.link_resp_packet_i[0] = 1'b0;
      for (int i = 0; i < 20 && m_cred < 16; i++) begin
         drive_a(2'b00, 1'b1, 1'b1, 2'b11);
         tick_a();
      end
      for (int i = 0; i < 2; i++) begin
         drive_a(2'b11, 1'b0, 1'b0, 2'b00);
         tick_a();
      end
      chk("send_before_reset", 128'(ifa.link_req_v_o), 128'(1));
      #3 reset_n = 1'b0;
      #1 chk("async_reset_link_v", 128'(ifa.link_req_v_o), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      chk("post_reset_credits", 128'(credits_a), 128'(16));
      drive_a(2'b11, 1'b1, 1'b0, 2'b00);
      tick_a();
      chk("post_reset_rr0", 128'(last_g), 128'(0));

      // Two-credit instance: exactly two accepted without responses.
      ifb.req_v_i = 2'b11; ifb.link_req_ready_i = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         #1 acc += $countones(ifb.req_ready_o);
         @(negedge clk);
      end
      chk("b_accepted", 128'(acc), 128'(2));
      chk("b_credits0", 128'(credits_b), 128'(0));
      ifb.link_resp_v_i = 1'b1; ifb.resp_ready_i = 2'b11;
      #1 chk("b_yumi", 128'(ifb.link_resp_yumi_o), 128'(1));
      chk("b_blocked", 128'(ifb.req_ready_o), 128'(0));
      @(negedge clk);
      ifb.link_resp_v_i = 1'b0;
      #1 chk("b_one_more", 128'(ifb.req_ready_o), 128'(2'b01));
      @(negedge clk);
      #1 chk("b_blocked_again", 128'(ifb.req_ready_o), 128'(0));
      @(negedge clk);
      ifb.req_v_i = 2'b00;
      #1;
`ifdef BSG_MANYCORE_HOST_LINK_ARBITER_STATS_EN
      chk("b_stall_count", 128'(stats_b[95:64]), 128'(6));
      chk("b_issued0", 128'(stats_b[31:0]), 128'(2));
      chk("b_issued1", 128'(stats_b[63:32]), 128'(1));
`else
      chk("b_stats_off", 128'(stats_b), 128'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bsg_manycore_host_link_arbiter.md
Name: bsg_manycore_host_link_arbiter

Overview:
- Shares the single host I/O link of the manycore mesh (the loader link at io x=0) among num_req_p host-side requesters, e.g. MMIO, DMA and loader.
- Round-robin, packet-granular grant. One registered output packet stage.
- Outstanding-request credit counter throttles the link.
- Each response is routed back to its requester by a tag that the block writes into the request packet.

Parameters:
- num_req_p, 2, number of host requesters (2..8).
- packet_width_p, 128, width of request and response packets in bits.
- tag_lsb_p, 0, LSB position of the requester tag field in both request and response packets (the low bits of reg_id).
- max_out_credits_p, 16, maximum outstanding requests on the link.
- tag_width_lp, clog2(num_req_p) (safe clog2), derived tag width.
- credit_width_lp, clog2(max_out_credits_p+1), derived counter width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous reset, active-low.
- req_v_i  in  num_req_p  per-requester request valid.
- req_packet_i  in  num_req_p*packet_width_p  per-requester request packet.
- req_ready_o  out  num_req_p  request accepted when v & ready.
- link_req_v_o  out  1  request valid toward the mesh host link.
- link_req_packet_o  out  packet_width_p  tagged request packet.
- link_req_ready_i  in  1  link accepts the request.
- link_resp_v_i  in  1  response valid from the link.
- link_resp_packet_i  in  packet_width_p  response packet, tag echoed.
- link_resp_yumi_o  out  1  response consumed.
- resp_v_o  out  num_req_p  one-hot response valid.
- resp_packet_o  out  packet_width_p  response packet, shared by all requesters.
- resp_ready_i  in  num_req_p  per-requester response ready.
- credits_o  out  credit_width_lp  free credits.
- stats_o  out  num_req_p*32+32  statistics (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; rr pointer=0; credits=max_out_credits_p.
  - All valid/ready/yumi outputs 0.
  - link_req_packet_o=0.
- FSM states: IDLE and SEND.
- IDLE:
  - If credits>0 and any req_v_i, pick the first requesting index at or after the rr pointer (wrapping).
  - Assert req_ready_o[g] for that index only, combinationally in the same cycle.
  - On handshake, register the packet with bits [tag_lsb_p +: tag_width_lp] overwritten by g.
  - Set rr pointer=(g+1) mod num_req_p. Decrement credits. Next state SEND.
  - If credits==0, all req_ready_o stay 0.
- SEND:
  - link_req_v_o=1 with the registered packet, held stable until link_req_ready_i.
  - On ready: if credits>0 and a request is pending, a new grant may be taken in the same cycle (back-to-back, 1 packet/cycle throughput) and the state stays SEND. Otherwise go to IDLE.
  - req_ready_o is asserted in SEND only on a cycle where link_req_ready_i=1.
- Request latency: accept at cycle t, link_req_v_o at t+1.
- Response path (combinational, no buffering):
  - t = response tag field.
  - resp_v_o[t]=link_resp_v_i; resp_packet_o=link_resp_packet_i.
  - link_resp_yumi_o=link_resp_v_i & resp_ready_i[t].
  - On yumi, credits increment.
- Simultaneous issue and yumi in one cycle: credits unchanged.
- Credit overflow (yumi with credits==max): must not occur. Assertion in simulation; saturate in RTL.
- Tag value >= num_req_p in a response: simulation error. RTL drops it with yumi=1 and still returns the credit.
- A requester deasserting req_v_i without a handshake is legal. It is not granted; the pointer is unchanged.

Optional Feature:
- Macro: BSG_MANYCORE_HOST_LINK_ARBITER_STATS_EN.
- When defined:
  - stats_o[i*32 +: 32] = per-requester 32-bit wrapping count of issued requests.
  - Top 32 bits = count of cycles with credits==0 and any req_v_i.
  - All counters cleared by reset.
- When undefined: stats_o is tied to 0 and no counter flops exist.

Decomposition:
- Shared package bsg_manycore_host_link_arbiter_pkg holds:
  - state enum {IDLE, SEND};
  - stats word width constant (32);
  - a tag insert/extract function parameterized by lsb and width.
- One sub-module, bsg_manycore_host_link_rr_pick (combinational): inputs req vector and pointer; outputs one-hot grant, grant index, any_v.

Test Plan:
- Reset, then num_req_p=2 with both requesting continuously and link ready=1 → grants alternate 0,1,0,1. Packets carry tags 0,1,0,1. credits_o drops 16→12 after 4 issues.
- max_out_credits_p=2, no responses → exactly 2 accepted, then req_ready_o=0. A stall counter (stats build) counts each blocked cycle. One yumi → one more accepted.
- link_req_ready_i=0 for 5 cycles during SEND → link_req_packet_o stable, req_ready_o=0. Ready on cycle 6 → next grant is taken that cycle.
- Response with tag=1 while resp_ready_i=2'b01 → resp_v_o=2'b10, yumi=0. Set ready[1]=1 → yumi=1 and credits+1.
- Issue and response yumi in the same cycle at credits=7 → credits stays 7.
- Assert reset_n_i low mid-SEND (asynchronously, between edges) → link_req_v_o falls immediately. After release: credits=max, state IDLE, rr pointer=0.
